// File: rtl/triangle_scan.sv
// Triangle scan generator: walks the signed bounding box of three vertices in
// row-major order and streams the points that pass the three-edge sign test.
module triangle_scan #(
  parameter bit          EMIT_ALL = 1'b0,
  parameter int unsigned CNT_W    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tri_valid,
  output logic             tri_ready,
  input  logic [11:0]      p1x,
  input  logic [11:0]      p1y,
  input  logic [11:0]      p2x,
  input  logic [11:0]      p2y,
  input  logic [11:0]      p3x,
  input  logic [11:0]      p3y,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [11:0]      pix_x,
  output logic [11:0]      pix_y,
  output logic             pix_in,
  output logic             done,
  output logic [CNT_W-1:0] pix_count
);

  localparam int unsigned CW = 12;
  localparam int unsigned DW = 13;
  localparam int unsigned PW = 26;
  localparam int unsigned EW = 27;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_FIN} state_t;

  state_t state;
  logic signed [CW-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
  logic signed [CW-1:0] xmin, xmax, ymax;
  logic signed [CW-1:0] cur_x, cur_y;

  logic signed [CW-1:0] bxmin_c, bxmax_c, bymin_c, bymax_c;
  logic signed [CW-1:0] nx_c, ny_c;
  logic                 s1_c, s2_c, s3_c, in_c, emit_c, last_c;

  function automatic logic signed [CW-1:0] min3(input logic signed [CW-1:0] a,
                                                input logic signed [CW-1:0] b,
                                                input logic signed [CW-1:0] c);
    logic signed [CW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [CW-1:0] max3(input logic signed [CW-1:0] a,
                                                input logic signed [CW-1:0] b,
                                                input logic signed [CW-1:0] c);
    logic signed [CW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Exact edge function sign: 13-bit differences, 26-bit products, 27-bit sum.
  function automatic logic edge_pos(input logic signed [CW-1:0] ax,
                                    input logic signed [CW-1:0] ay,
                                    input logic signed [CW-1:0] bx,
                                    input logic signed [CW-1:0] by,
                                    input logic signed [CW-1:0] px,
                                    input logic signed [CW-1:0] py);
    logic signed [DW-1:0] dpx, dpy, dax, day;
    logic signed [PW-1:0] m0, m1;
    logic signed [EW-1:0] e;
    dpx = DW'(px) - DW'(bx);
    dpy = DW'(py) - DW'(by);
    dax = DW'(ax) - DW'(bx);
    day = DW'(ay) - DW'(by);
    m0  = PW'(dpx) * PW'(day);
    m1  = PW'(dax) * PW'(dpy);
    e   = EW'(m0) - EW'(m1);
    return !e[EW-1];
  endfunction

  // Next candidate to present and its inside test.
  always_comb begin
    bxmin_c = min3(v1x, v2x, v3x);
    bxmax_c = max3(v1x, v2x, v3x);
    bymin_c = min3(v1y, v2y, v3y);
    bymax_c = max3(v1y, v2y, v3y);
    nx_c    = cur_x;
    ny_c    = cur_y;
    if (state == S_SETUP) begin
      nx_c = bxmin_c;
      ny_c = bymin_c;
    end else if (cur_x == xmax) begin
      nx_c = xmin;
      ny_c = cur_y + 12'sd1;
    end else begin
      nx_c = cur_x + 12'sd1;
    end
    s1_c   = edge_pos(v1x, v1y, v2x, v2y, nx_c, ny_c);
    s2_c   = edge_pos(v2x, v2y, v3x, v3y, nx_c, ny_c);
    s3_c   = edge_pos(v3x, v3y, v1x, v1y, nx_c, ny_c);
    in_c   = (s1_c == s2_c) && (s2_c == s3_c);
    emit_c = EMIT_ALL || in_c;
    last_c = (cur_x == xmax) && (cur_y == ymax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tri_ready <= 1'b0;
      pix_valid <= 1'b0;
      pix_in    <= 1'b0;
      done      <= 1'b0;
      pix_count <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      xmin      <= '0;
      xmax      <= '0;
      ymax      <= '0;
      v1x <= '0; v1y <= '0; v2x <= '0; v2y <= '0; v3x <= '0; v3y <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tri_ready <= 1'b1;
          if (tri_valid && tri_ready) begin
            v1x <= p1x; v1y <= p1y; v2x <= p2x; v2y <= p2y; v3x <= p3x; v3y <= p3y;
            tri_ready <= 1'b0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          xmin      <= bxmin_c;
          xmax      <= bxmax_c;
          ymax      <= bymax_c;
          pix_count <= '0;
          cur_x     <= nx_c;
          cur_y     <= ny_c;
          pix_valid <= emit_c;
          pix_in    <= EMIT_ALL ? in_c : 1'b1;
          state     <= S_SCAN;
        end
        S_SCAN: begin
          // A held point retires only on pix_ready; a skipped candidate always retires.
          if (!pix_valid || pix_ready) begin
            if (pix_valid && pix_in) pix_count <= pix_count + CNT_W'(1);
            if (last_c) begin
              pix_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_FIN;
            end else begin
              cur_x     <= nx_c;
              cur_y     <= ny_c;
              pix_valid <= emit_c;
              pix_in    <= EMIT_ALL ? in_c : 1'b1;
            end
          end
        end
        S_FIN: begin
          done      <= 1'b0;
          tri_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pix_x = cur_x;
  assign pix_y = cur_y;

endmodule

// File: tb/tb_triangle_scan.sv
// Bench for triangle_scan: directed and random triangles against a point-list
// model, with one instance per EMIT_ALL setting.
module tb_triangle_scan;

  logic        clk;
  logic        rst_n;
  logic        tri_valid0, tri_valid1;
  logic [11:0] p1x, p1y, p2x, p2y, p3x, p3y;
  logic        pix_ready;

  logic        tri_ready0, pix_valid0, pix_in0, done0;
  logic        tri_ready1, pix_valid1, pix_in1, done1;
  logic [11:0] pix_x0, pix_y0, pix_x1, pix_y1;
  logic [23:0] pix_count0, pix_count1;

  int sel;
  logic        o_tri_ready, o_valid, o_in, o_done;
  logic [11:0] o_x, o_y;
  logic [23:0] o_count;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct { int x; int y; bit in; } pt_t;
  pt_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  triangle_scan #(.EMIT_ALL(1'b0), .CNT_W(24)) dut0 (
    .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid0), .tri_ready(tri_ready0),
    .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
    .pix_valid(pix_valid0), .pix_ready(pix_ready), .pix_x(pix_x0), .pix_y(pix_y0),
    .pix_in(pix_in0), .done(done0), .pix_count(pix_count0));

  triangle_scan #(.EMIT_ALL(1'b1), .CNT_W(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid1), .tri_ready(tri_ready1),
    .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
    .pix_valid(pix_valid1), .pix_ready(pix_ready), .pix_x(pix_x1), .pix_y(pix_y1),
    .pix_in(pix_in1), .done(done1), .pix_count(pix_count1));

  assign o_tri_ready = (sel != 0) ? tri_ready1 : tri_ready0;
  assign o_valid     = (sel != 0) ? pix_valid1 : pix_valid0;
  assign o_in        = (sel != 0) ? pix_in1    : pix_in0;
  assign o_done      = (sel != 0) ? done1      : done0;
  assign o_x         = (sel != 0) ? pix_x1     : pix_x0;
  assign o_y         = (sel != 0) ? pix_y1     : pix_y0;
  assign o_count     = (sel != 0) ? pix_count1 : pix_count0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_chk++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint edge_val(input int ax, input int ay, input int bx,
                                      input int by, input int px, input int py);
    return longint'(px - bx) * longint'(ay - by) - longint'(ax - bx) * longint'(py - by);
  endfunction

  function automatic int imin(input int a, input int b, input int c);
    int m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int imax(input int a, input int b, input int c);
    int m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  task automatic set_valid(input int s, input logic v);
    if (s != 0) tri_valid1 = v; else tri_valid0 = v;
  endtask

  // rmode 0: pix_ready held high; rmode 1: random pix_ready plus a mid-scan tri_valid pulse.
  task automatic run_tri(input int s, input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int rmode, input int abort_n,
                         input int exp_pts);
    int nbox = 0, cnt_in = 0, nemit = 0, busy_bad = 0, k, bound, w, dseen;
    bit finished = 0, prev_hold = 0;
    longint prev_word = 0;
    longint e1, e2, e3;
    bit in;
    pt_t e;

    sel = s;
    tri_valid0 = 1'b0;
    tri_valid1 = 1'b0;
    exp_q.delete();
    for (int y = imin(ay, by, cy); y <= imax(ay, by, cy); y++) begin
      for (int x = imin(ax, bx, cx); x <= imax(ax, bx, cx); x++) begin
        e1 = edge_val(ax, ay, bx, by, x, y);
        e2 = edge_val(bx, by, cx, cy, x, y);
        e3 = edge_val(cx, cy, ax, ay, x, y);
        in = ((e1 >= 0) == (e2 >= 0)) && ((e2 >= 0) == (e3 >= 0));
        nbox++;
        if (in) cnt_in++;
        if (s != 0 || in) exp_q.push_back('{x: x, y: y, in: in});
      end
    end
    bound = 4 * nbox + 20;

    p1x = 12'(ax); p1y = 12'(ay); p2x = 12'(bx); p2y = 12'(by); p3x = 12'(cx); p3y = 12'(cy);
    @(negedge clk);
    w = 0;
    while (!o_tri_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("tri_ready_idle", longint'(o_tri_ready), 1);
    set_valid(s, 1'b1);
    pix_ready = (rmode == 1) ? 1'($urandom_range(1)) : 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_valid(s, 1'b0);
    p1x = 12'($urandom); p1y = 12'($urandom); p2x = 12'($urandom);
    p2y = 12'($urandom); p3x = 12'($urandom); p3y = 12'($urandom);
    k = 1;

    while (!finished) begin
      if (prev_hold)
        chk("hold_stable", longint'({o_valid, o_x, o_y, o_in}), prev_word);
      if (o_done) begin
        set_valid(s, 1'b0);
        chk("done_queue_empty", longint'(exp_q.size()), 0);
        chk("pix_count", longint'(o_count), longint'(cnt_in));
        if (rmode == 0) chk("done_latency", longint'(k), longint'(2 + nbox));
        if (exp_pts >= 0) chk("n_points", longint'(nemit), longint'(exp_pts));
        chk("tri_ready_busy", longint'(busy_bad), 0);
        @(negedge clk);
        chk("count_hold", longint'(o_count), longint'(cnt_in));
        finished = 1;
      end else begin
        if (o_tri_ready) busy_bad++;
        set_valid(s, (rmode == 1) && (k == 6));
        pix_ready = (rmode == 1) ? 1'($urandom_range(1)) : 1'b1;
        prev_hold = o_valid && !pix_ready;
        prev_word = longint'({o_valid, o_x, o_y, o_in});
        if (o_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_point", longint'({o_x, o_y}), -1);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("point%0d", nemit),
                longint'({o_x, o_y, o_in}), longint'({12'(e.x), 12'(e.y), e.in}));
          end
          nemit++;
        end
        if (abort_n > 0 && nemit == abort_n) begin
          @(negedge clk);
          rst_n = 1'b0;
          #1;
          chk("rst_outputs", longint'({o_tri_ready, o_valid, o_x, o_y, o_in, o_done}), 0);
          chk("rst_count", longint'(o_count), 0);
          dseen = 0;
          repeat (3) begin
            @(posedge clk);
            #1 dseen += int'(o_done);
          end
          @(negedge clk);
          rst_n = 1'b1;
          repeat (4) begin
            @(negedge clk);
            dseen += int'(o_done);
          end
          chk("no_done_after_abort", longint'(dseen), 0);
          exp_q.delete();
          finished = 1;
        end else if (k > bound) begin
          chk("scan_timeout", longint'(k), longint'(bound));
          finished = 1;
        end else begin
          @(negedge clk);
          k++;
        end
      end
    end
    set_valid(s, 1'b0);
  endtask

  initial begin
    int ox, oy;
    rst_n = 1'b0;
    sel = 0;
    tri_valid0 = 1'b0;
    tri_valid1 = 1'b0;
    pix_ready = 1'b0;
    {p1x, p1y, p2x, p2y, p3x, p3y} = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs0", longint'({tri_ready0, pix_valid0, pix_x0, pix_y0, pix_in0, done0}), 0);
    chk("reset_count0", longint'(pix_count0), 0);
    chk("reset_outputs1", longint'({tri_ready1, pix_valid1, pix_x1, pix_y1, pix_in1, done1}), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("tri_ready_after_reset", longint'(tri_ready0), 1);

    run_tri(0, 0, 0, 4, 0, 0, 4, 0, 0, 15);
    run_tri(0, 0, 0, 0, 4, 4, 0, 0, 0, 3);
    run_tri(0, -2, -2, 2, -2, -2, 2, 0, 0, 15);
    run_tri(0, -2048, 0, 2047, 0, 2047, 1, 0, 0, 4097);
    run_tri(1, -2048, 0, 2047, 0, 2047, 1, 0, 0, 8192);
    run_tri(0, 0, 0, 4, 0, 0, 4, 1, 0, 15);
    run_tri(1, 0, 0, 4, 0, 0, 4, 1, 0, 25);
    run_tri(0, 0, 0, 4, 0, 0, 4, 0, 5, -1);
    run_tri(0, 5, 5, 5, 5, 5, 5, 0, 0, 1);
    run_tri(1, 5, 5, 5, 5, 5, 5, 0, 0, 1);

    for (int i = 0; i < 10; i++) begin
      ox = int'($urandom_range(3000)) - 1500;
      oy = int'($urandom_range(3000)) - 1500;
      run_tri(i % 2,
              ox + int'($urandom_range(16)) - 8, oy + int'($urandom_range(16)) - 8,
              ox + int'($urandom_range(16)) - 8, oy + int'($urandom_range(16)) - 8,
              ox + int'($urandom_range(16)) - 8, oy + int'($urandom_range(16)) - 8,
              int'($urandom_range(1)), 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/triangle_scan.md
# triangle_scan

Triangle scan generator. Accepts three 12-bit signed vertices, walks their bounding box in row-major order, and emits the candidate points that pass the edge-sign inside test, at one candidate per clock over a valid/ready stream. It is the producer side of the point-in-triangle path: it generates the (x, y) stream that the inside test consumes, so a whole triangle is covered without an external point source.

## Interface
- EMIT_ALL, 0, 1 = emit every bounding-box point with `pix_in` flagging inside; 0 = emit inside points only
- CNT_W, 24, width of `pix_count`
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tri_valid  in  1  vertex set offered
- tri_ready  out  1  block can accept a vertex set
- p1x, p1y, p2x, p2y, p3x, p3y  in  12 each  vertex coordinates, two's complement
- pix_valid  out  1  pix_x / pix_y / pix_in valid
- pix_ready  in  1  downstream accepts the point
- pix_x, pix_y  out  12 each  point coordinates, signed
- pix_in  out  1  point is inside (constant 1 when EMIT_ALL=0)
- done  out  1  one-cycle pulse, scan complete
- pix_count  out  CNT_W  number of inside points in the last scan

## Operation
- Edge value for ordered pair (A, B) at point P: E = (Px−Bx)·(Ay−By) − (Ax−Bx)·(Py−By). Differences are 13-bit signed, products 26-bit signed, and E is evaluated at ≥27-bit signed full precision. No truncation is allowed.
- Sign bit s = (E ≥ 0). Edges are (p1,p2), (p2,p3) and (p3,p1). A point is inside iff s1 == s2 == s3.
- Consequence: boundary points are included only when the winding gives non-negative interior values. Clockwise triangles exclude their edges. This is required behaviour.
- Bounding box: xmin/xmax and ymin/ymax use signed compares. Scan order is y from ymin to ymax; within each row, x from xmin to xmax.
- Loop termination compares against the max value and never relies on counter wrap; x = 2047 must terminate the row.
- FSM:
  - IDLE: tri_ready=1. On tri_valid&&tri_ready, latch the vertices and go to SETUP.
  - SETUP: one cycle. Compute the bbox and the starting edge values; pix_count ← 0. Go to SCAN.
  - SCAN: evaluate the current candidate. Emitted points (inside, or any point when EMIT_ALL) assert pix_valid and hold until pix_ready. Non-emitted candidates take exactly one cycle. After the last candidate retires, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- pix_count increments on each accepted inside point. It holds its value from DONE until the next SETUP.
- Edge values may be updated incrementally or recomputed per candidate. Either way, results must equal the exact formula.

## Timing
- Reset values: tri_ready=0 during reset and 1 in the first cycle after release (IDLE). pix_valid=0, pix_x=0, pix_y=0, pix_in=0, done=0, pix_count=0.
- Handshake accepted at cycle N → SETUP at N+1 → first candidate in SCAN at N+2. With no stalls, the first pix_valid can be high at N+2.
- Throughput: one candidate per cycle while pix_ready=1.
- pix_valid must not drop, and pix_x/pix_y/pix_in must not change, until pix_ready is sampled high.
- pix_ready is ignored when pix_valid=0.
- done asserts the cycle after the last candidate retires (last emitted handshake, or last non-emitted evaluation cycle).
- tri_ready is 0 in SETUP, SCAN and DONE. A tri_valid seen outside IDLE is not consumed.
- Degenerate inputs:
  - A single-point or zero-area bbox still scans.
  - All-equal vertices give E=0 on all edges, so the single point is inside.
- rst_n asserted mid-scan: immediate return to reset values, no done pulse, and the in-progress triangle is discarded.

## Test plan
- CCW (0,0),(4,0),(0,4), EMIT_ALL=0, pix_ready=1:
  - Exactly 15 points, first (0,0), last (0,4), row-major order.
  - Row y=0 is x=0..4.
  - done at 2 + 25 cycles after accept; pix_count=15.
- CW (0,0),(0,4),(4,0):
  - Only (1,1),(2,1),(1,2), in that order.
  - pix_count=3; all edge and vertex points excluded.
- Negative coordinates, CCW (−2,−2),(2,−2),(−2,2):
  - 15 points, first (−2,−2), last (−2,2).
  - Point (0,0) emitted, (1,0) not emitted.
- Extreme coordinates, (−2048,0),(2047,0),(2047,1):
  - 4097 points: all 4096 of row y=0 plus (2047,1).
  - Scan terminates with no x wrap; pix_count=4097.
  - Repeat with EMIT_ALL=1: 8192 points, 4097 of them with pix_in=1.
- Backpressure on the (0,0),(4,0),(0,4) case:
  - Random pix_ready with ~50% duty.
  - Same 15-point sequence; held data stays stable while stalled; tri_ready=0 until after done.
- Reset mid-scan on the (0,0),(4,0),(0,4) case:
  - Drop rst_n after the 5th point: all outputs go to reset values and no done pulse appears.
  - Re-submit (5,5),(5,5),(5,5): exactly one point (5,5), pix_count=1.
